// File: rtl/mips32_pipeline_cpu.sv
// Five-stage in-order MIPS32 integer core: IF, ID, EX, MEM, WB with full forwarding,
// load-use interlock, not-taken branch prediction resolved in EX and jumps resolved in ID.
module mips32_pipeline_cpu #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned REG_COUNT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] imem_data,
   input  logic        imem_ready,
   output logic [31:0] imem_addr,
   input  logic [31:0] dmem_rdata,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [31:0] cycle_count,
   output logic [31:0] inst_count,
   output logic [31:0] branch_predict_correct,
   output logic [31:0] branch_predict_total
);
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                          OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                          OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
      ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PC4
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   typedef struct packed {
      logic        valid;
      alu_op_e     op;
      logic        use_imm, reg_write, mem_read, mem_write, is_beq, is_bne;
      logic [4:0]  rs, rt, dest, shamt;
      logic [31:0] rs_val, rt_val, imm, pc4;
   } idex_t;

   typedef struct packed {
      logic        valid, reg_write, mem_read, mem_write;
      logic [4:0]  rt, dest;
      logic [31:0] result, store;
   } exmem_t;

   typedef struct packed {
      logic        valid, reg_write;
      logic [4:0]  dest;
      logic [31:0] wdata;
   } memwb_t;

   logic [31:0] pc_q, pc_d;
   ifid_t       ifid_q, ifid_d;
   idex_t       idex_q, idex_d;
   exmem_t      exmem_q, exmem_d;
   memwb_t      memwb_q, memwb_d;
   logic [31:0] regs_q [REG_COUNT];
   logic [31:0] cyc_q, inst_q, bp_ok_q, bp_tot_q;

   logic        wb_we, jump, load_use, uses_rs, uses_rt, branch_taken, is_branch;
   logic [5:0]  opc, fn;
   logic [4:0]  rs, rt;
   logic [31:0] rf_rs, rf_rt, fwd_rs, fwd_rt, alu_b, alu, br_target, j_target, pc4_if;

   assign wb_we = memwb_q.valid && memwb_q.reg_write && (memwb_q.dest != 5'd0);
   assign opc   = ifid_q.instr[31:26];
   assign fn    = ifid_q.instr[5:0];
   assign rs    = ifid_q.instr[25:21];
   assign rt    = ifid_q.instr[20:16];

   // Register read with same-cycle bypass of the WB write.
   always_comb begin
      rf_rs = (rs == 5'd0) ? '0 : (wb_we && memwb_q.dest == rs) ? memwb_q.wdata : regs_q[rs];
      rf_rt = (rt == 5'd0) ? '0 : (wb_we && memwb_q.dest == rt) ? memwb_q.wdata : regs_q[rt];
   end

   always_comb begin
      idex_d          = '0;
      idex_d.valid    = ifid_q.valid;
      idex_d.op       = ALU_ADD;
      idex_d.rs       = rs;
      idex_d.rt       = rt;
      idex_d.shamt    = ifid_q.instr[10:6];
      idex_d.rs_val   = rf_rs;
      idex_d.rt_val   = rf_rt;
      idex_d.imm      = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
      idex_d.pc4      = ifid_q.pc4;
      uses_rs         = 1'b1;
      uses_rt         = 1'b0;
      jump            = 1'b0;
      case (opc)
         OP_R: begin
            uses_rt          = 1'b1;
            idex_d.reg_write = 1'b1;
            idex_d.dest      = ifid_q.instr[15:11];
            case (fn)
               6'h00: begin idex_d.op = ALU_SLL; uses_rs = 1'b0; end
               6'h02: begin idex_d.op = ALU_SRL; uses_rs = 1'b0; end
               6'h03: begin idex_d.op = ALU_SRA; uses_rs = 1'b0; end
               6'h20, 6'h21: idex_d.op = ALU_ADD;
               6'h22, 6'h23: idex_d.op = ALU_SUB;
               6'h24: idex_d.op = ALU_AND;
               6'h25: idex_d.op = ALU_OR;
               6'h26: idex_d.op = ALU_XOR;
               6'h27: idex_d.op = ALU_NOR;
               6'h2A: idex_d.op = ALU_SLT;
               6'h2B: idex_d.op = ALU_SLTU;
               default: begin idex_d.reg_write = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; end
            endcase
         end
         OP_J:   begin jump = 1'b1; uses_rs = 1'b0; end
         OP_JAL: begin
            jump = 1'b1; uses_rs = 1'b0;
            idex_d.reg_write = 1'b1; idex_d.dest = 5'd31; idex_d.op = ALU_PC4;
         end
         OP_BEQ: begin idex_d.is_beq = 1'b1; uses_rt = 1'b1; end
         OP_BNE: begin idex_d.is_bne = 1'b1; uses_rt = 1'b1; end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
            idex_d.use_imm = 1'b1; idex_d.reg_write = 1'b1; idex_d.dest = rt;
            if (opc == OP_SLTI)  idex_d.op = ALU_SLT;
            if (opc == OP_SLTIU) idex_d.op = ALU_SLTU;
            if (opc == OP_ANDI)  idex_d.op = ALU_AND;
            if (opc == OP_ORI)   idex_d.op = ALU_OR;
            if (opc == OP_XORI)  idex_d.op = ALU_XOR;
            if (opc == OP_LUI)   begin idex_d.op = ALU_LUI; uses_rs = 1'b0; end
            if (opc == OP_LW)    idex_d.mem_read = 1'b1;
            if (opc == OP_ANDI || opc == OP_ORI || opc == OP_XORI)
               idex_d.imm = {16'h0000, ifid_q.instr[15:0]};
         end
         // sw store data is not an interlock source: a lw ahead reaches it through MEM-stage forwarding.
         OP_SW:   begin idex_d.use_imm = 1'b1; idex_d.mem_write = 1'b1; end
         default: uses_rs = 1'b0;
      endcase
      jump     = jump && ifid_q.valid;
      load_use = ifid_q.valid && idex_q.valid && idex_q.mem_read && (idex_q.dest != 5'd0) &&
                 ((uses_rs && idex_q.dest == rs) || (uses_rt && idex_q.dest == rt));
      if (!ifid_q.valid || load_use || branch_taken) idex_d = '0;
   end

   always_comb begin
      fwd_rs = idex_q.rs_val;
      fwd_rt = idex_q.rt_val;
      if (idex_q.rs != 5'd0 && exmem_q.valid && exmem_q.reg_write && !exmem_q.mem_read &&
          exmem_q.dest == idex_q.rs)                     fwd_rs = exmem_q.result;
      else if (wb_we && memwb_q.dest == idex_q.rs)       fwd_rs = memwb_q.wdata;
      if (idex_q.rt != 5'd0 && exmem_q.valid && exmem_q.reg_write && !exmem_q.mem_read &&
          exmem_q.dest == idex_q.rt)                     fwd_rt = exmem_q.result;
      else if (wb_we && memwb_q.dest == idex_q.rt)       fwd_rt = memwb_q.wdata;
   end

   always_comb begin
      alu_b = idex_q.use_imm ? idex_q.imm : fwd_rt;
      alu   = '0;
      case (idex_q.op)
         ALU_ADD:  alu = fwd_rs + alu_b;
         ALU_SUB:  alu = fwd_rs - alu_b;
         ALU_AND:  alu = fwd_rs & alu_b;
         ALU_OR:   alu = fwd_rs | alu_b;
         ALU_XOR:  alu = fwd_rs ^ alu_b;
         ALU_NOR:  alu = ~(fwd_rs | alu_b);
         ALU_SLT:  alu = {31'b0, $signed(fwd_rs) < $signed(alu_b)};
         ALU_SLTU: alu = {31'b0, fwd_rs < alu_b};
         ALU_SLL:  alu = fwd_rt << idex_q.shamt;
         ALU_SRL:  alu = fwd_rt >> idex_q.shamt;
         ALU_SRA:  alu = $unsigned($signed(fwd_rt) >>> idex_q.shamt);
         ALU_LUI:  alu = {idex_q.imm[15:0], 16'h0000};
         ALU_PC4:  alu = idex_q.pc4;
         default:  alu = '0;
      endcase
      is_branch    = idex_q.valid && (idex_q.is_beq || idex_q.is_bne);
      branch_taken = idex_q.valid && ((idex_q.is_beq && fwd_rs == fwd_rt) ||
                                      (idex_q.is_bne && fwd_rs != fwd_rt));
      br_target    = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};
      exmem_d      = '{valid: idex_q.valid, reg_write: idex_q.reg_write, mem_read: idex_q.mem_read,
                       mem_write: idex_q.mem_write, rt: idex_q.rt, dest: idex_q.dest,
                       result: alu, store: fwd_rt};
   end

   // The WB instruction is always the one directly ahead of the store, so its value is the newest.
   assign dmem_wdata = (wb_we && memwb_q.dest == exmem_q.rt) ? memwb_q.wdata : exmem_q.store;
   assign dmem_addr  = exmem_q.result;
   assign dmem_we    = exmem_q.valid && exmem_q.mem_write;
   assign memwb_d    = '{valid: exmem_q.valid, reg_write: exmem_q.reg_write, dest: exmem_q.dest,
                         wdata: exmem_q.mem_read ? dmem_rdata : exmem_q.result};

   assign pc4_if   = pc_q + 32'd4;
   assign j_target = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};

   always_comb begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      if (branch_taken) begin
         pc_d   = br_target;
         ifid_d = '0;
      end else if (load_use) begin
         pc_d   = pc_q;
      end else if (jump) begin
         pc_d   = j_target;
         ifid_d = '0;
      end else if (!imem_ready) begin
         ifid_d = '0;
      end else begin
         pc_d   = pc4_if;
         ifid_d = '{valid: 1'b1, instr: imem_data, pc4: pc4_if};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         ifid_q   <= '0;
         idex_q   <= '0;
         exmem_q  <= '0;
         memwb_q  <= '0;
         cyc_q    <= '0;
         inst_q   <= '0;
         bp_ok_q  <= '0;
         bp_tot_q <= '0;
         for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else begin
         pc_q     <= pc_d;
         ifid_q   <= ifid_d;
         idex_q   <= idex_d;
         exmem_q  <= exmem_d;
         memwb_q  <= memwb_d;
         cyc_q    <= cyc_q + 32'd1;
         inst_q   <= inst_q + {31'b0, memwb_q.valid};
         bp_tot_q <= bp_tot_q + {31'b0, is_branch};
         bp_ok_q  <= bp_ok_q + {31'b0, is_branch && !branch_taken};
         if (wb_we) regs_q[memwb_q.dest] <= memwb_q.wdata;
      end
   end

   assign imem_addr              = pc_q;
   assign cycle_count            = cyc_q;
   assign inst_count             = inst_q;
   assign branch_predict_correct = bp_ok_q;
   assign branch_predict_total   = bp_tot_q;
endmodule

// File: tb/tb_mips32_pipeline_cpu.sv
// Scoreboard bench for mips32_pipeline_cpu: directed programs push expected stores
// (address, data, cycle_count, inst_count); a monitor checks each dmem_we strobe.
module tb_mips32_pipeline_cpu;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_ready = 1'b1;
   logic [31:0] imem_data, imem_addr, dmem_rdata, dmem_addr, dmem_wdata;
   logic        dmem_we;
   logic [31:0] cycle_count, inst_count, bp_correct, bp_total;

   logic [31:0] rom [64];
   logic [31:0] ram [64];
   logic [31:0] prog [$];

   typedef struct {
      logic [31:0] addr, data, cyc, inst;
   } exp_t;
   exp_t sb [$];

   int total = 0;
   int bad   = 0;

   mips32_pipeline_cpu #(.RESET_PC(32'h0000_0000), .REG_COUNT(32)) dut (
      .clk(clk), .reset(reset), .imem_data(imem_data), .imem_ready(imem_ready),
      .imem_addr(imem_addr), .dmem_rdata(dmem_rdata), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .cycle_count(cycle_count),
      .inst_count(inst_count), .branch_predict_correct(bp_correct),
      .branch_predict_total(bp_total)
   );

   always #5 clk = ~clk;

   assign imem_data  = rom[imem_addr[7:2]];
   assign dmem_rdata = ram[dmem_addr[7:2]];
   always @(posedge clk) if (dmem_we) ram[dmem_addr[7:2]] <= dmem_wdata;

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                         input int sh, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction
   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] enc_j(input int op, input int tgt);
      return {6'(op), 26'(tgt)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && dmem_we === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_store: got addr=%0d data=%0d expected no store",
                     dmem_addr, dmem_wdata);
         end else begin
            e = sb.pop_front();
            chk("store_addr", dmem_addr, e.addr);
            chk("store_data", dmem_wdata, e.data);
            chk("store_cycle", cycle_count, e.cyc);
            chk("store_inst_count", inst_count, e.inst);
         end
      end
   end

   task automatic push_exp(input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] c, input logic [31:0] n);
      exp_t e;
      e.addr = a; e.data = d; e.cyc = c; e.inst = n;
      sb.push_back(e);
   endtask

   task automatic start();
      @(negedge clk);
      reset      = 1'b1;
      imem_ready = 1'b1;
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
      for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending stores expected 0", sb.size());
         sb.delete();
      end
      repeat (15) @(negedge clk);
   endtask

   task automatic load_sum();
      prog.delete();
      prog.push_back(enc_i(8, 0, 1, 0));           // addi $1,$0,0
      prog.push_back(enc_i(8, 0, 2, 1));           // addi $2,$0,1
      prog.push_back(enc_i(8, 0, 3, 21));          // addi $3,$0,21
      prog.push_back(enc_r(1, 2, 1, 0, 'h20));     // add  $1,$1,$2
      prog.push_back(enc_i(8, 2, 2, 1));           // addi $2,$2,1
      prog.push_back(enc_i(5, 2, 3, -3));          // bne  $2,$3,loop
      prog.push_back(enc_i('h2B, 0, 1, 252));      // sw   $1,252($0)
      prog.push_back(enc_j(2, 7));                 // j    self
   endtask

   task automatic load_chain();
      prog.delete();
      prog.push_back(enc_i(8, 0, 1, 5));           // addi $1,$0,5
      prog.push_back(enc_r(1, 1, 2, 0, 'h20));     // add  $2,$1,$1
      prog.push_back(enc_r(2, 1, 3, 0, 'h20));     // add  $3,$2,$1
      prog.push_back(enc_i('h2B, 0, 3, 0));        // sw   $3,0($0)
      prog.push_back(enc_j(2, 4));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100000ns");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_imem_addr", imem_addr, 32'd0);
      chk("reset_dmem_we", {31'b0, dmem_we}, 32'd0);
      chk("reset_dmem_addr", dmem_addr, 32'd0);
      chk("reset_dmem_wdata", dmem_wdata, 32'd0);
      chk("reset_cycle_count", cycle_count, 32'd0);
      chk("reset_inst_count", inst_count, 32'd0);
      chk("reset_bp_total", bp_total, 32'd0);
      chk("reset_bp_correct", bp_correct, 32'd0);

      // Sum 1..20: 19 taken + 1 not-taken bne, store on cycle 104 with 62 retired.
      load_sum();
      push_exp(252, 210, 104, 62);
      start();
      drain(1000);
      chk("sum_bp_total", bp_total, 32'd20);
      chk("sum_bp_correct", bp_correct, 32'd1);

      // Dependent ALU chain, no stalls.
      load_chain();
      push_exp(0, 15, 6, 2);
      start();
      drain(100);

      // Load-use: one bubble delays the second store's retire count.
      prog.delete();
      prog.push_back(enc_i(8, 0, 6, 7));           // addi $6,$0,7
      prog.push_back(enc_i('h2B, 0, 6, 4));        // sw   $6,4($0)
      prog.push_back(enc_i('h23, 0, 4, 4));        // lw   $4,4($0)
      prog.push_back(enc_r(4, 4, 5, 0, 'h20));     // add  $5,$4,$4
      prog.push_back(enc_i('h2B, 0, 5, 8));        // sw   $5,8($0)
      prog.push_back(enc_j(2, 5));
      push_exp(4, 7, 4, 0);
      push_exp(8, 14, 8, 3);
      start();
      drain(100);

      // Taken beq skips two addi; not-taken bne falls through.
      prog.delete();
      prog.push_back(enc_i(8, 0, 1, 3));           // addi $1,$0,3
      prog.push_back(enc_i(8, 0, 2, 3));           // addi $2,$0,3
      prog.push_back(enc_i(4, 1, 2, 2));           // beq  $1,$2,+2
      prog.push_back(enc_i(8, 0, 7, 99));          // skipped
      prog.push_back(enc_i(8, 0, 8, 99));          // skipped
      prog.push_back(enc_i(5, 1, 2, 1));           // bne  $1,$2,+1 (not taken)
      prog.push_back(enc_i('h2B, 0, 7, 16));
      prog.push_back(enc_i('h2B, 0, 8, 20));
      prog.push_back(enc_i('h2B, 0, 1, 24));
      prog.push_back(enc_j(2, 9));
      push_exp(16, 0, 9, 3);
      push_exp(20, 0, 10, 4);
      push_exp(24, 3, 11, 5);
      start();
      drain(100);
      chk("br_bp_total", bp_total, 32'd2);
      chk("br_bp_correct", bp_correct, 32'd1);

      // Fetch stall of 3 cycles after the second fetch: store moves from cycle 6 to 9.
      load_chain();
      push_exp(0, 15, 9, 2);
      start();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall_imem_addr", imem_addr, 32'd8);
      end
      imem_ready = 1'b1;
      drain(100);

      // Reset mid-loop, then the program re-runs from scratch.
      load_sum();
      push_exp(252, 210, 104, 62);
      start();
      repeat (40) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset_imem_addr", imem_addr, 32'd0);
      chk("midreset_cycle_count", cycle_count, 32'd0);
      chk("midreset_inst_count", inst_count, 32'd0);
      chk("midreset_bp_total", bp_total, 32'd0);
      chk("midreset_bp_correct", bp_correct, 32'd0);
      chk("midreset_dmem_we", {31'b0, dmem_we}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drain(1000);
      chk("rerun_bp_total", bp_total, 32'd20);
      chk("rerun_bp_correct", bp_correct, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
